synchronous_two_output_demultiplexer: RTL and testbench

SYNCHRONOUS_TWO_OUTPUT_DEMULTIPLEXER -- requirements
Module: synchronous_two_output_demultiplexer

---
 rtl/synchronous_two_output_demultiplexer.sv | 69 ++++++
 tb/tb_synchronous_two_output_demultiplexer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synchronous_two_output_demultiplexer.sv
// Routes each accepted input word to one of two outputs, each path buffered by
// an independent 2-entry FIFO with valid/ready handshakes on both sides.
module synchronous_two_output_demultiplexer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);

  logic [WIDTH-1:0] mem_q [2][2];
  logic [1:0]       cnt_q [2];
  logic             rd_q  [2];
  logic             wr_q  [2];
  logic [1:0]       push;
  logic [1:0]       pop;

  // Readiness depends only on the selected path's fill level, never on the
  // downstream ready, so a full path stays blocked even while it drains.
  always_comb begin
    in_ready = select ? (cnt_q[1] != 2'd2) : (cnt_q[0] != 2'd2);
    push[0]  = in_valid & in_ready & ~select;
    push[1]  = in_valid & in_ready & select;
    pop[0]   = out0_valid & out0_ready;
    pop[1]   = out1_valid & out1_ready;
  end

  assign out0_valid = (cnt_q[0] != 2'd0);
  assign out1_valid = (cnt_q[1] != 2'd0);
  assign out0_data  = mem_q[0][rd_q[0]];
  assign out1_data  = mem_q[1][rd_q[1]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        cnt_q[p]    <= 2'd0;
        rd_q[p]     <= 1'b0;
        wr_q[p]     <= 1'b0;
        mem_q[p][0] <= '0;
        mem_q[p][1] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) begin
          mem_q[p][wr_q[p]] <= in_data;
          wr_q[p]           <= ~wr_q[p];
        end
        if (pop[p]) begin
          rd_q[p] <= ~rd_q[p];
        end
        unique case ({push[p], pop[p]})
          2'b10:   cnt_q[p] <= cnt_q[p] + 2'd1;
          2'b01:   cnt_q[p] <= cnt_q[p] - 2'd1;
          default: cnt_q[p] <= cnt_q[p];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_synchronous_two_output_demultiplexer.sv
// Self-checking bench: directed scenarios plus a randomized run, all compared
// against a queue-based model of the two buffered paths.
module tb_synchronous_two_output_demultiplexer;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             select = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready = 1'b0;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  synchronous_two_output_demultiplexer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .select     (select),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit v, input bit sel, input logic [WIDTH-1:0] d,
                       input bit r0, input bit r1);
    in_valid   = v;
    select     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
  endtask

  // Advance one clock, applying the model's view of the same edge.
  task automatic tick();
    bit pop0, pop1, acc;
    logic [WIDTH-1:0] d;
    pop0 = (q0.size() != 0) && out0_ready;
    pop1 = (q1.size() != 0) && out1_ready;
    acc  = in_valid && ((select ? q1.size() : q0.size()) < 2);
    d    = in_data;
    @(posedge clk);
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (acc && !select) q0.push_back(d);
      if (acc && select) q1.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, '0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      drive(0, s[0], '0, 0, 0);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
      end
    end
    checks++;
    if ({out0_valid, out1_valid} !== 2'b00 || out0_data !== '0 || out1_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b%b d0=%h d1=%h exp v=00 d=0",
               out0_valid, out1_valid, out0_data, out1_data);
    end
  endtask

  task automatic test_route();
    do_reset();
    drive(1, 0, 16'hA5A5, 1, 1);
    tick();
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 16'hA5A5 || out1_valid !== 1'b0) begin
      failures++;
      $display("FAIL route_out0 got v0=%b d0=%h v1=%b exp v0=1 d0=a5a5 v1=0",
               out0_valid, out0_data, out1_valid);
    end
    drive(1, 1, 16'h5A5A, 1, 1);
    tick();
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 16'h5A5A || out0_valid !== 1'b0) begin
      failures++;
      $display("FAIL route_out1 got v1=%b d1=%h v0=%b exp v1=1 d1=5a5a v0=0",
               out1_valid, out1_data, out0_valid);
    end
    drive(0, 0, '0, 1, 1);
    tick();
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      failures++;
      $display("FAIL route_single_cycle got v0=%b v1=%b exp 0 0", out0_valid, out1_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, WIDTH'(i), 0, 0);
      checks++;
      if (in_ready !== (i < 3)) begin
        failures++;
        $display("FAIL bp_accept word=%0d got=%b exp=%b", i, in_ready, i < 3);
      end
      tick();
    end
    drive(1, 0, 16'h0003, 1, 0);
    checks++;
    if (in_ready !== 1'b0 || out0_data !== 16'h0001 || out0_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_full_drain got rdy=%b v0=%b d0=%h exp rdy=0 v0=1 d0=0001",
               in_ready, out0_valid, out0_data);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out0_data !== 16'h0002) begin
      failures++;
      $display("FAIL bp_second got rdy=%b d0=%h exp rdy=1 d0=0002", in_ready, out0_data);
    end
    tick();
    drive(0, 0, '0, 1, 0);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 16'h0003) begin
      failures++;
      $display("FAIL bp_third got v0=%b d0=%h exp v0=1 d0=0003", out0_valid, out0_data);
    end
    tick();
    checks++;
    if (out0_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty got v0=%b exp 0", out0_valid);
    end
  endtask

  task automatic test_independence();
    do_reset();
    drive(1, 0, 16'hAAAA, 0, 0);
    tick();
    drive(1, 0, 16'hBBBB, 0, 0);
    tick();
    drive(1, 1, 16'h00FF, 0, 0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL indep_ready got=%b exp=1", in_ready);
    end
    tick();
    drive(0, 0, '0, 0, 0);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 16'h00FF || out0_data !== 16'hAAAA ||
        in_ready !== 1'b0) begin
      failures++;
      $display("FAIL indep_paths got v1=%b d1=%h d0=%h rdy0=%b exp 1 00ff aaaa 0",
               out1_valid, out1_data, out0_data, in_ready);
    end
    drive(0, 0, '0, 1, 0);
    tick();
    checks++;
    if (out0_data !== 16'hBBBB || out0_valid !== 1'b1) begin
      failures++;
      $display("FAIL indep_order got v0=%b d0=%h exp 1 bbbb", out0_valid, out0_data);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1, 1, 16'h1111, 0, 0);
    tick();
    drive(1, 1, 16'h2222, 0, 1);
    checks++;
    if (out1_data !== 16'h1111 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_pre got d1=%h rdy=%b exp 1111 1", out1_data, in_ready);
    end
    tick();
    drive(0, 1, '0, 0, 1);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 16'h2222) begin
      failures++;
      $display("FAIL simul_post got v1=%b d1=%h exp 1 2222", out1_valid, out1_data);
    end
    tick();
    checks++;
    if (out1_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_count got v1=%b exp 0", out1_valid);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, i[1], WIDTH'(16'hC000 + i), 0, 0);
      tick();
    end
    drive(0, 0, '0, 1, 1);
    reset = 1'b1;
    #1;
    checks++;
    if ({out0_valid, out1_valid} !== 2'b00 || out0_data !== '0 || out1_data !== '0) begin
      failures++;
      $display("FAIL midreset_async got v=%b%b d0=%h d1=%h exp 00 0 0",
               out0_valid, out1_valid, out0_data, out1_data);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, i[0], '0, 1, 1);
      checks++;
      if ({out0_valid, out1_valid} !== 2'b00 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL midreset_stale cyc=%0d got v=%b%b rdy=%b exp 00 1",
                 i, out0_valid, out1_valid, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, WIDTH'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      checks++;
      if (in_ready !== ((select ? q1.size() : q0.size()) < 2) ||
          out0_valid !== (q0.size() != 0) || out1_valid !== (q1.size() != 0) ||
          (q0.size() != 0 && out0_data !== q0[0]) ||
          (q1.size() != 0 && out1_data !== q1[0])) begin
        failures++;
        $display("FAIL random cyc=%0d got rdy=%b v=%b%b d0=%h d1=%h exp sizes %0d %0d",
                 c, in_ready, out0_valid, out1_valid, out0_data, out1_data,
                 q0.size(), q1.size());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_route();
    test_backpressure();
    test_independence();
    test_simultaneous();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
